// File: rtl/prio_encoder_8to3_seq_pkg.sv
// Shared constants and state type for the sequential priority encoder.
package prio_enc_pkg;
   localparam int N_REQ_DEF  = 8;
   localparam int CODE_W_DEF = $clog2(N_REQ_DEF);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } enc_state_t;
endpackage

// File: rtl/prio_encoder_8to3_seq_if.sv
// Request lines, enable, code handshake and 74LS148-style group signals.
interface prio_encoder_8to3_seq_if
   import prio_enc_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int CODE_W = $clog2(N_REQ)
);
   logic [N_REQ-1:0]  req_n;
   logic              ei_n;
   logic              ready;
   logic [CODE_W-1:0] code;
   logic              valid;
   logic              gs_n;
   logic              eo_n;
   logic              ovf;

   modport master (output req_n, ei_n, ready,
                   input  code, valid, gs_n, eo_n, ovf);
   modport slave  (input  req_n, ei_n, ready,
                   output code, valid, gs_n, eo_n, ovf);
endinterface

// File: rtl/prio_encoder_8to3_seq_pick.sv
// Combinational highest-set-bit finder with an any-set flag.
module prio_pick #(
   parameter int N_REQ  = 8,
   parameter int CODE_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0]  vec_i,
   output logic [CODE_W-1:0] idx_o,
   output logic              any_o
);
   // Ascending scan: the last set bit seen is the highest index.
   always_comb begin
      idx_o = '0;
      any_o = |vec_i;
      for (int i = 0; i < N_REQ; i++) begin
         if (vec_i[i]) idx_o = CODE_W'(i);
      end
   end
endmodule

// File: rtl/prio_encoder_8to3_seq.sv
// Falling-edge capture into a sticky pending set, served highest index first
// through a one-deep valid/ready output register.
module prio_encoder_8to3_seq
   import prio_enc_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int CODE_W = $clog2(N_REQ)
) (
   input logic                    clk,
   input logic                    rst_n,
   prio_encoder_8to3_seq_if.slave bus
);
   logic [N_REQ-1:0]  req_q, pend_q, pend_d, cap, load_mask;
   logic [CODE_W-1:0] code_q, code_d, pick_idx;
   logic              pick_any, load, ovf_q, ovf_d, valid;
   enc_state_t        state_q, state_d;

   prio_pick #(.N_REQ(N_REQ), .CODE_W(CODE_W)) u_pick (
      .vec_i (pend_q),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign valid = (state_q == FULL);

   // Pick sees only registered pending, so this cycle's edges wait one clock.
   always_comb begin
      cap       = bus.ei_n ? '0 : (req_q & ~bus.req_n);
      load      = !bus.ei_n && pick_any && (!valid || bus.ready);
      load_mask = load ? (N_REQ'(1) << pick_idx) : '0;
      pend_d    = (pend_q & ~load_mask) | cap;
      ovf_d     = ovf_q | (|(cap & pend_q & ~load_mask));
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      case (state_q)
         EMPTY: if (load) begin
            state_d = FULL;
            code_d  = pick_idx;
         end
         FULL: if (bus.ready) begin
            if (load) code_d  = pick_idx;
            else      state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '1;
         pend_q  <= '0;
         code_q  <= '0;
         ovf_q   <= 1'b0;
         state_q <= EMPTY;
      end else begin
         req_q   <= bus.req_n;
         pend_q  <= pend_d;
         code_q  <= code_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
      end
   end

   assign bus.code  = code_q;
   assign bus.valid = valid;
   assign bus.ovf   = ovf_q;
   assign bus.gs_n  = ~valid;
   assign bus.eo_n  = bus.ei_n | (|pend_q) | valid;
endmodule

// File: tb/tb_prio_encoder_8to3_seq.sv
// Directed scenarios plus random traffic, checked every cycle against a
// behavioural model of the capture/pending/serve rules.
module tb_prio_encoder_8to3_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   prio_encoder_8to3_seq_if #(.N_REQ(8)) bus ();

   prio_encoder_8to3_seq #(.N_REQ(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   bit [7:0] m_prev;
   bit       m_pend [8];
   bit       m_valid;
   int       m_code;
   bit       m_ovf;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0d want %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_prev  = 8'hFF;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_code  = 0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_adv(input bit [7:0] rq, input bit ei, input bit rdy);
      int hi;
      bit take, e, clr;
      bit np [8];
      hi = -1;
      for (int i = 7; i >= 0; i--) if (m_pend[i] && hi < 0) hi = i;
      take = !ei && (hi >= 0) && (!m_valid || rdy);
      for (int i = 0; i < 8; i++) begin
         e   = !ei && m_prev[i] && !rq[i];
         clr = take && (i == hi);
         if (e && m_pend[i] && !clr) m_ovf = 1'b1;
         np[i] = (m_pend[i] && !clr) || e;
      end
      m_pend = np;
      if (take) begin
         m_valid = 1'b1;
         m_code  = hi;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      m_prev = rq;
   endtask

   task automatic check_model();
      bit anyp;
      anyp = 1'b0;
      foreach (m_pend[i]) anyp |= m_pend[i];
      chk("valid", bus.valid, m_valid);
      if (m_valid) chk("code", bus.code, m_code);
      chk("gs_n", bus.gs_n, !m_valid);
      chk("eo_n", bus.eo_n, (!bus.ei_n && !anyp && !m_valid) ? 0 : 1);
      chk("ovf", bus.ovf, m_ovf);
   endtask

   // Drive after the edge, check at the falling edge, then advance the model.
   task automatic step(input bit [7:0] rq, input bit ei, input bit rdy, input bit rst);
      @(posedge clk);
      #2;
      bus.req_n = rq;
      bus.ei_n  = ei;
      bus.ready = rdy;
      rst_n     = rst;
      @(negedge clk);
      cyc++;
      if (!rst_n) model_reset();
      check_model();
      if (rst_n) model_adv(rq, ei, rdy);
   endtask

   bit [7:0] rq;

   initial begin
      rst_n     = 1'b0;
      bus.req_n = 8'hFF;
      bus.ei_n  = 1'b0;
      bus.ready = 1'b0;
      model_reset();

      // Reset state
      step(8'hFF, 0, 0, 0);
      step(8'hFF, 0, 0, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_code", bus.code, 0);
      chk("rst_gs_n", bus.gs_n, 1);
      chk("rst_eo_n", bus.eo_n, 0);
      chk("rst_ovf", bus.ovf, 0);
      step(8'hFF, 0, 0, 1);

      // Single request on line 5, held low
      step(8'hDF, 0, 1, 1);
      step(8'hDF, 0, 1, 1);
      chk("single_valid_early", bus.valid, 0);
      step(8'hDF, 0, 1, 1);
      chk("single_valid", bus.valid, 1);
      chk("single_code", bus.code, 5);
      step(8'hDF, 0, 1, 1);
      chk("single_drop", bus.valid, 0);
      step(8'hDF, 0, 1, 1);
      step(8'hDF, 0, 1, 1);
      chk("single_no_repeat", bus.valid, 0);
      step(8'hFF, 0, 1, 1);

      // Simultaneous 1, 6, 3
      step(8'hB5, 0, 1, 1);
      step(8'hB5, 0, 1, 1);
      step(8'hB5, 0, 1, 1);
      chk("prio_code0", bus.code, 6);
      step(8'hB5, 0, 1, 1);
      chk("prio_code1", bus.code, 3);
      step(8'hFF, 0, 1, 1);
      chk("prio_code2", bus.code, 1);
      chk("prio_valid2", bus.valid, 1);
      step(8'hFF, 0, 1, 1);
      chk("prio_done", bus.valid, 0);

      // Backpressure: code 2 held, line 7 falls meanwhile
      step(8'hFB, 0, 0, 1);
      step(8'hFB, 0, 0, 1);
      step(8'h7B, 0, 0, 1);
      chk("bp_code", bus.code, 2);
      for (int k = 0; k < 4; k++) begin
         step(8'h7B, 0, 0, 1);
         chk("bp_hold", bus.code, 2);
      end
      step(8'h7B, 0, 1, 1);
      chk("bp_accept_code", bus.code, 2);
      step(8'hFF, 0, 1, 1);
      chk("bp_next_valid", bus.valid, 1);
      chk("bp_next_code", bus.code, 7);
      step(8'hFF, 0, 1, 1);
      chk("bp_done", bus.valid, 0);

      // Enable high: no capture
      step(8'hEF, 1, 0, 1);
      chk("ei_eo_n", bus.eo_n, 1);
      step(8'hEF, 1, 0, 1);
      step(8'hEF, 0, 0, 1);
      step(8'hFF, 0, 0, 1);
      step(8'hFF, 0, 0, 1);
      chk("ei_no_cap", bus.valid, 0);
      chk("ei_eo_n_back", bus.eo_n, 0);

      // Overflow: line 0 pulses twice while code 3 is stalled
      step(8'hF7, 0, 0, 1);
      step(8'hF7, 0, 0, 1);
      step(8'hF6, 0, 0, 1);
      chk("ovf_code3", bus.code, 3);
      step(8'hF7, 0, 0, 1);
      step(8'hF6, 0, 0, 1);
      chk("ovf_clear", bus.ovf, 0);
      step(8'hF7, 0, 0, 1);
      chk("ovf_set", bus.ovf, 1);
      step(8'hFF, 0, 1, 1);
      step(8'hFF, 0, 1, 1);
      chk("ovf_code0", bus.code, 0);
      chk("ovf_valid0", bus.valid, 1);
      step(8'hFF, 0, 1, 1);
      chk("ovf_once", bus.valid, 0);
      step(8'hFF, 0, 1, 1);
      chk("ovf_once2", bus.valid, 0);
      chk("ovf_sticky", bus.ovf, 1);

      // Async reset in the middle of a burst 7, 5, 2
      step(8'h5B, 0, 1, 1);
      step(8'h5B, 0, 1, 1);
      step(8'h5B, 0, 1, 1);
      chk("burst_code", bus.code, 7);
      @(posedge clk);
      #3;
      rst_n     = 1'b0;
      bus.req_n = 8'hFF;
      #1;
      chk("arst_valid", bus.valid, 0);
      chk("arst_gs_n", bus.gs_n, 1);
      chk("arst_eo_n", bus.eo_n, 0);
      chk("arst_ovf", bus.ovf, 0);
      model_reset();
      @(negedge clk);
      cyc++;
      check_model();
      step(8'hFF, 0, 1, 0);
      step(8'hFF, 0, 1, 1);
      for (int k = 0; k < 4; k++) begin
         step(8'hFF, 0, 1, 1);
         chk("arst_no_code", bus.valid, 0);
      end

      // Random traffic
      rq = 8'hFF;
      for (int k = 0; k < 600; k++) begin
         for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
         step(rq, $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
